cordic_vec_sched: RTL and testbench

Round-robin scheduler that shares one pipelined CORDIC vectoring engine among `NUM_REQ` requesters. It sits in front of the rotation datapath and the angle-accumulation stage. It does four things:
- grants one requester per cycle;
- issues the granted requester's quadrant code with a valid strobe;
- generates the per-stage micro-rotation enables;
- returns a result strobe tagged with the requester ID, aligned with the registered angle output.

Each requester may have at most one operation in flight.

---
 rtl/cordic_vec_sched.sv | 77 +++++++
 tb/tb_cordic_vec_sched.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cordic_vec_sched.sv
// cordic_vec_sched: round-robin issue scheduler, stage-enable token pipe and tagged result strobe for a shared CORDIC vectoring engine
module cordic_vec_sched #(
  parameter int NUM_REQ       = 4,
  parameter int CORDIC_STAGES = 16,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [NUM_REQ-1:0]       req_in,
  input  logic [2*NUM_REQ-1:0]     quad_in,
  input  logic                     hold_in,
  output logic [NUM_REQ-1:0]       gnt_out,
  output logic                     issue_vld_out,
  output logic [1:0]               quad_out,
  output logic [ID_WIDTH-1:0]      issue_id_out,
  output logic [CORDIC_STAGES-1:0] enable_out,
  output logic [NUM_REQ-1:0]       busy_out,
  output logic                     res_vld_out,
  output logic [ID_WIDTH-1:0]      res_id_out,
  output logic [NUM_REQ-1:0]       done_out,
  output logic                     idle_out
);
  logic [ID_WIDTH-1:0] rr_ptr, win;
  logic found, go;
  int j;
  logic [NUM_REQ-1:0] elig, set_m, clr_m;
  logic [CORDIC_STAGES:0] tok;
  logic [CORDIC_STAGES:0][ID_WIDTH-1:0] ids;
  assign elig = req_in & ~busy_out;
  // scan from the farthest offset down so the nearest eligible index at/after rr_ptr wins
  always_comb begin
    win = '0;
    found = 1'b0;
    j = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (elig[j]) begin
        win = ID_WIDTH'(j);
        found = 1'b1;
      end
    end
  end
  assign go    = found & ~hold_in;
  assign set_m = go ? NUM_REQ'(1) << win : '0;
  // the token leaving the last stage retires its owner on the same edge res_vld_out rises
  assign clr_m = tok[CORDIC_STAGES-1] ? NUM_REQ'(1) << ids[CORDIC_STAGES-1] : '0;
  assign enable_out  = tok[CORDIC_STAGES-1:0];
  assign res_vld_out = tok[CORDIC_STAGES];
  assign res_id_out  = ids[CORDIC_STAGES];
  assign idle_out    = ~|tok & ~issue_vld_out & ~|busy_out;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gnt_out       <= '0;
      issue_vld_out <= 1'b0;
      quad_out      <= '0;
      issue_id_out  <= '0;
      rr_ptr        <= '0;
      busy_out      <= '0;
      tok           <= '0;
      ids           <= '0;
      done_out      <= '0;
    end else begin
      gnt_out       <= set_m;
      issue_vld_out <= go;
      if (go) begin
        quad_out     <= quad_in[2*win +: 2];
        issue_id_out <= win;
        rr_ptr       <= win == ID_WIDTH'(NUM_REQ-1) ? '0 : win + 1'b1;
      end
      busy_out <= (busy_out | set_m) & ~clr_m;
      tok      <= {tok[CORDIC_STAGES-1:0], issue_vld_out};
      ids      <= {ids[CORDIC_STAGES-1:0], issue_id_out};
      done_out <= clr_m;
    end
  end
endmodule

// File: tb/tb_cordic_vec_sched.sv
// tb_cordic_vec_sched: directed checks of grant order, stage enables, done timing, hold and reset
module tb_cordic_vec_sched;
  localparam int N = 4;
  localparam int S = 16;
  localparam int W = 2;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic hold_in = 1'b0;
  logic [N-1:0] req_in = '0;
  logic [2*N-1:0] quad_in = 8'b10_11_01_00;
  logic [N-1:0] gnt_out, busy_out, done_out;
  logic issue_vld_out, res_vld_out, idle_out;
  logic [1:0] quad_out;
  logic [W-1:0] issue_id_out, res_id_out;
  logic [S-1:0] enable_out;
  logic [N-1:0] seen;
  logic [N-1:0] eg, ed;
  int total = 0;
  int bad = 0;
  cordic_vec_sched #(.NUM_REQ(N), .CORDIC_STAGES(S)) dut (
    .clk(clk), .nreset(nreset), .req_in(req_in), .quad_in(quad_in), .hold_in(hold_in),
    .gnt_out(gnt_out), .issue_vld_out(issue_vld_out), .quad_out(quad_out),
    .issue_id_out(issue_id_out), .enable_out(enable_out), .busy_out(busy_out),
    .res_vld_out(res_vld_out), .res_id_out(res_id_out), .done_out(done_out),
    .idle_out(idle_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, ".gnt"}, 32'(gnt_out), 0);
    chk({tag, ".vld"}, 32'(issue_vld_out), 0);
    chk({tag, ".quad"}, 32'(quad_out), 0);
    chk({tag, ".id"}, 32'(issue_id_out), 0);
    chk({tag, ".en"}, 32'(enable_out), 0);
    chk({tag, ".busy"}, 32'(busy_out), 0);
    chk({tag, ".rvld"}, 32'(res_vld_out), 0);
    chk({tag, ".rid"}, 32'(res_id_out), 0);
    chk({tag, ".done"}, 32'(done_out), 0);
    chk({tag, ".idle"}, 32'(idle_out), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_rst("por");
    nreset = 1'b1;
    @(negedge clk);
    req_in = 4'b0100;
    @(negedge clk);
    chk("single.gnt", 32'(gnt_out), 32'h4);
    chk("single.vld", 32'(issue_vld_out), 1);
    chk("single.quad", 32'(quad_out), 3);
    chk("single.id", 32'(issue_id_out), 2);
    chk("single.busy0", 32'(busy_out), 32'h4);
    chk("single.idle0", 32'(idle_out), 0);
    req_in = '0;
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      chk($sformatf("single.en%0d", k), 32'(enable_out), 32'(1) << k);
      chk($sformatf("single.busy%0d", k + 1), 32'(busy_out), 32'h4);
      chk($sformatf("single.rvld%0d", k + 1), 32'(res_vld_out), 0);
    end
    @(negedge clk);
    chk("single.rvld", 32'(res_vld_out), 1);
    chk("single.rid", 32'(res_id_out), 2);
    chk("single.done", 32'(done_out), 32'h4);
    chk("single.busyclr", 32'(busy_out), 0);
    chk("single.en_end", 32'(enable_out), 0);
    @(negedge clk);
    chk("single.done_end", 32'(done_out), 0);
    chk("single.idle", 32'(idle_out), 1);
    req_in = 4'b0011;
    for (int c = 0; c <= 20; c++) begin
      eg = c == 0 ? 4'b0001 : c == 1 ? 4'b0010 : (c == 2 || c == 20) ? 4'b1000 : 4'b0000;
      ed = c == 17 ? 4'b0001 : c == 18 ? 4'b0010 : c == 19 ? 4'b1000 : 4'b0000;
      @(negedge clk);
      chk($sformatf("wrap.gnt%0d", c), 32'(gnt_out), 32'(eg));
      chk($sformatf("wrap.done%0d", c), 32'(done_out), 32'(ed));
      if (c == 2) chk("wrap.quad3", 32'(quad_out), 2);
      if (c == 2) chk("wrap.id3", 32'(issue_id_out), 3);
      if (c == 1) req_in = 4'b1000;
      if (c == 20) req_in = '0;
    end
    repeat (20) @(negedge clk);
    chk("wrap.idle", 32'(idle_out), 1);
    req_in = 4'b1111;
    for (int c = 0; c <= 26; c++) begin
      eg = c < 4 ? 4'(1 << c) : c == 18 ? 4'b0001 : c == 19 ? 4'b0010 :
           c == 25 ? 4'b0100 : c == 26 ? 4'b1000 : 4'b0000;
      ed = (c >= 17 && c <= 20) ? 4'(1 << (c - 17)) : 4'b0000;
      @(negedge clk);
      chk($sformatf("rr.gnt%0d", c), 32'(gnt_out), 32'(eg));
      chk($sformatf("rr.done%0d", c), 32'(done_out), 32'(ed));
      if (c == 19) hold_in = 1'b1;
      if (c == 24) hold_in = 1'b0;
      if (c == 26) req_in = '0;
    end
    repeat (7) @(negedge clk);
    #2 nreset = 1'b0;
    #1 chk_rst("midrst");
    @(negedge clk);
    nreset = 1'b1;
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen |= done_out | busy_out;
    end
    chk("midrst.nodone", 32'(seen), 0);
    req_in = 4'b0010;
    @(negedge clk);
    chk("post.gnt", 32'(gnt_out), 32'h2);
    req_in = '0;
    repeat (16) @(negedge clk);
    chk("post.early", 32'(done_out), 0);
    @(negedge clk);
    chk("post.done", 32'(done_out), 32'h2);
    chk("post.rid", 32'(res_id_out), 1);
    req_in = 4'b1111;
    repeat (3) @(negedge clk);
    #2 nreset = 1'b0;
    #1 chk_rst("trafrst");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("trafrst.gnt0", 32'(gnt_out), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
